// File: rtl/superscalar_rob_if.sv
// Dispatch, result-bus and commit signals of the superscalar reorder buffer.
// The ROB owns the slave side; the front end / testbench owns the master side.
interface superscalar_rob_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ROB_SIZE       = 16,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int NUM_CDB        = 2
);
    localparam int TW = $clog2(ROB_SIZE);

    logic                                     flush_i;
    logic                                     mispredict_i;
    logic [TW-1:0]                            mispredict_tag_i;
    logic [DISPATCH_WIDTH-1:0]                dispatch_valid_i;
    logic [DISPATCH_WIDTH*PC_WIDTH-1:0]       dispatch_pc_i;
    logic [DISPATCH_WIDTH*REG_ADDR_WIDTH-1:0] dispatch_rd_addr_i;
    logic                                     dispatch_ready_o;
    logic [DISPATCH_WIDTH*TW-1:0]             dispatch_tag_o;
    logic [NUM_CDB-1:0]                       cdb_valid_i;
    logic [NUM_CDB*TW-1:0]                    cdb_tag_i;
    logic [NUM_CDB*DATA_WIDTH-1:0]            cdb_data_i;
    logic [NUM_CDB-1:0]                       cdb_exc_valid_i;
    logic [NUM_CDB*32-1:0]                    cdb_exc_cause_i;
    logic [COMMIT_WIDTH-1:0]                  commit_valid_o;
    logic [COMMIT_WIDTH*PC_WIDTH-1:0]         commit_pc_o;
    logic [COMMIT_WIDTH*REG_ADDR_WIDTH-1:0]   commit_rd_addr_o;
    logic [COMMIT_WIDTH*DATA_WIDTH-1:0]       commit_result_o;
    logic [COMMIT_WIDTH-1:0]                  commit_exc_valid_o;
    logic [COMMIT_WIDTH*32-1:0]               commit_exc_cause_o;
    logic                                     commit_ready_i;
    logic [TW:0]                              count_o;

    modport master (
        output flush_i, mispredict_i, mispredict_tag_i,
        output dispatch_valid_i, dispatch_pc_i, dispatch_rd_addr_i,
        input  dispatch_ready_o, dispatch_tag_o,
        output cdb_valid_i, cdb_tag_i, cdb_data_i, cdb_exc_valid_i, cdb_exc_cause_i,
        input  commit_valid_o, commit_pc_o, commit_rd_addr_o, commit_result_o,
        input  commit_exc_valid_o, commit_exc_cause_o,
        output commit_ready_i,
        input  count_o
    );

    modport slave (
        input  flush_i, mispredict_i, mispredict_tag_i,
        input  dispatch_valid_i, dispatch_pc_i, dispatch_rd_addr_i,
        output dispatch_ready_o, dispatch_tag_o,
        input  cdb_valid_i, cdb_tag_i, cdb_data_i, cdb_exc_valid_i, cdb_exc_cause_i,
        output commit_valid_o, commit_pc_o, commit_rd_addr_o, commit_result_o,
        output commit_exc_valid_o, commit_exc_cause_o,
        input  commit_ready_i,
        output count_o
    );
endinterface

// File: rtl/superscalar_rob.sv
// Circular reorder buffer: multi-lane in-order dispatch, out-of-order CDB
// completion, in-order multi-lane commit with precise exceptions and flush.
module superscalar_rob #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ROB_SIZE       = 16,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int NUM_CDB        = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    superscalar_rob_if.slave   rob
);
    localparam int TW = $clog2(ROB_SIZE);
    localparam logic [TW:0] SIZE = (TW+1)'(ROB_SIZE);
    localparam logic [TW:0] ONE  = (TW+1)'(1);
    localparam logic [TW:0] DWN  = (TW+1)'(DISPATCH_WIDTH);

    logic [ROB_SIZE-1:0]       r_busy, r_ready, r_exc_valid;
    logic [PC_WIDTH-1:0]       r_pc     [ROB_SIZE];
    logic [REG_ADDR_WIDTH-1:0] r_rd     [ROB_SIZE];
    logic [DATA_WIDTH-1:0]     r_result [ROB_SIZE];
    logic [31:0]               r_cause  [ROB_SIZE];
    logic [TW-1:0]             r_head, r_tail;
    logic [TW:0]               r_count;

    logic                      w_disp_ok;
    logic [DISPATCH_WIDTH-1:0] w_disp_en;
    logic [TW:0]               w_disp_n, w_ret_n, w_mp_count;
    logic [COMMIT_WIDTH-1:0]   w_cv;
    logic [TW-1:0]             w_age;
    logic [ROB_SIZE-1:0]       w_squash;

    assign rob.dispatch_ready_o = (SIZE - r_count) >= DWN;
    assign rob.count_o          = r_count;
    assign rob.commit_valid_o   = w_cv;
    assign w_disp_ok = rob.dispatch_ready_o && !rob.flush_i && !rob.mispredict_i;

    always_comb begin
        logic w_run;
        w_run     = 1'b1;
        w_disp_n  = '0;
        w_disp_en = '0;
        rob.dispatch_tag_o = '0;
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
            rob.dispatch_tag_o[k*TW +: TW] = r_tail + TW'(k);
            if (!rob.dispatch_valid_i[k]) w_run = 1'b0;
            w_disp_en[k] = w_disp_ok && w_run;
            if (w_disp_en[k]) w_disp_n = w_disp_n + ONE;
        end
    end

    // Commit stops after the first non-ready lane and after any excepting lane.
    always_comb begin
        logic          w_stop;
        logic [TW-1:0] w_idx;
        w_stop  = 1'b0;
        w_ret_n = '0;
        w_cv    = '0;
        rob.commit_pc_o        = '0;
        rob.commit_rd_addr_o   = '0;
        rob.commit_result_o    = '0;
        rob.commit_exc_valid_o = '0;
        rob.commit_exc_cause_o = '0;
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            w_idx = r_head + TW'(i);
            w_cv[i] = !w_stop && ((TW+1)'(i) < r_count) && r_ready[w_idx]
                      && (i == 0 || !r_exc_valid[w_idx]);
            if (!w_cv[i] || r_exc_valid[w_idx]) w_stop = 1'b1;
            if (w_cv[i] && rob.commit_ready_i) w_ret_n = w_ret_n + ONE;
            rob.commit_pc_o[i*PC_WIDTH +: PC_WIDTH]                 = r_pc[w_idx];
            rob.commit_rd_addr_o[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = r_rd[w_idx];
            rob.commit_result_o[i*DATA_WIDTH +: DATA_WIDTH]         = r_result[w_idx];
            rob.commit_exc_valid_o[i]                               = r_exc_valid[w_idx];
            rob.commit_exc_cause_o[i*32 +: 32]                      = r_cause[w_idx];
        end
    end

    always_comb begin
        w_age      = rob.mispredict_tag_i - r_head;
        w_mp_count = ({1'b0, w_age} < w_ret_n) ? '0 : {1'b0, w_age} + ONE - w_ret_n;
        for (int unsigned e = 0; e < ROB_SIZE; e++)
            w_squash[e] = (TW'(e) - r_head) > w_age;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_ready <= '0;
        end else if (rob.flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_ready <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_CDB; p++)
                if (rob.cdb_valid_i[p] && r_busy[rob.cdb_tag_i[p*TW +: TW]])
                    r_ready[rob.cdb_tag_i[p*TW +: TW]] <= 1'b1;
            for (int unsigned k = 0; k < DISPATCH_WIDTH; k++)
                if (w_disp_en[k]) begin
                    r_busy[r_tail + TW'(k)]  <= 1'b1;
                    r_ready[r_tail + TW'(k)] <= 1'b0;
                end
            for (int unsigned i = 0; i < COMMIT_WIDTH; i++)
                if (w_cv[i] && rob.commit_ready_i) begin
                    r_busy[r_head + TW'(i)]  <= 1'b0;
                    r_ready[r_head + TW'(i)] <= 1'b0;
                end
            r_head <= r_head + w_ret_n[TW-1:0];
            if (rob.mispredict_i) begin
                for (int unsigned e = 0; e < ROB_SIZE; e++)
                    if (w_squash[e]) begin
                        r_busy[e]  <= 1'b0;
                        r_ready[e] <= 1'b0;
                    end
                r_tail  <= rob.mispredict_tag_i + TW'(1);
                r_count <= w_mp_count;
            end else begin
                r_tail  <= r_tail + w_disp_n[TW-1:0];
                r_count <= r_count + w_disp_n - w_ret_n;
            end
        end
    end

    // Payload needs no reset; ports are scanned high to low so port 0 wins a tag clash.
    always_ff @(posedge clk_i) begin
        for (int unsigned p = NUM_CDB; p > 0; p--)
            if (rob.cdb_valid_i[p-1] && r_busy[rob.cdb_tag_i[(p-1)*TW +: TW]]) begin
                r_result[rob.cdb_tag_i[(p-1)*TW +: TW]]    <= rob.cdb_data_i[(p-1)*DATA_WIDTH +: DATA_WIDTH];
                r_exc_valid[rob.cdb_tag_i[(p-1)*TW +: TW]] <= rob.cdb_exc_valid_i[p-1];
                r_cause[rob.cdb_tag_i[(p-1)*TW +: TW]]     <= rob.cdb_exc_cause_i[(p-1)*32 +: 32];
            end
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++)
            if (w_disp_en[k]) begin
                r_pc[r_tail + TW'(k)]        <= rob.dispatch_pc_i[k*PC_WIDTH +: PC_WIDTH];
                r_rd[r_tail + TW'(k)]        <= rob.dispatch_rd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                r_exc_valid[r_tail + TW'(k)] <= 1'b0;
            end
    end
endmodule

// File: tb/tb_superscalar_rob.sv
// Scoreboard bench for superscalar_rob: dispatched entries are queued in
// program order and checked against each retiring commit lane.
module tb_superscalar_rob;
    localparam int N = 16, TW = 4, DW = 2, CW = 2, NC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    superscalar_rob_if #(.ROB_SIZE(N), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW), .NUM_CDB(NC)) bus ();
    superscalar_rob #(.ROB_SIZE(N), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW), .NUM_CDB(NC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rob(bus)
    );

    typedef struct { logic [3:0] tag; logic [31:0] pc; logic [4:0] rd; } ent_t;
    ent_t        q[$];
    logic [31:0] m_res[N];
    logic [31:0] m_cause[N];
    logic        m_exc[N];
    logic        m_rdy[N];
    logic [3:0]  m_tail;
    int          n_tests = 0, n_fail = 0;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rob(input logic [3:0] t);
        foreach (q[i]) if (q[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [CW-1:0] exp_cv();
        logic [CW-1:0] v = '0;
        for (int i = 0; i < CW; i++) begin
            if (i >= q.size()) break;
            if (!m_rdy[q[i].tag]) break;
            if (i > 0 && (m_exc[q[i].tag] || m_exc[q[i-1].tag])) break;
            v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_clear();
        q.delete();
        m_tail = '0;
        for (int t = 0; t < N; t++) m_rdy[t] = 1'b0;
    endtask

    task automatic set_disp(input int n);
        for (int k = 0; k < DW; k++) begin
            bus.dispatch_valid_i[k]         = (k < n);
            bus.dispatch_pc_i[k*32 +: 32]   = $urandom;
            bus.dispatch_rd_addr_i[k*5 +: 5] = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic set_cdb(input int p, input logic [3:0] t, input logic exc);
        bus.cdb_valid_i[p]            = 1'b1;
        bus.cdb_tag_i[p*TW +: TW]     = t;
        bus.cdb_data_i[p*32 +: 32]    = $urandom;
        bus.cdb_exc_valid_i[p]        = exc;
        bus.cdb_exc_cause_i[p*32 +: 32] = $urandom;
    endtask

    // Check visible state, update the model for this cycle, then clock.
    task automatic tick();
        logic [CW-1:0] cv;
        logic [3:0]    t;
        bit            rdy;
        ent_t          e;
        cv  = exp_cv();
        rdy = (N - q.size()) >= DW;
        expect_eq("commit_valid", bus.commit_valid_o, cv);
        expect_eq("count", bus.count_o, q.size());
        expect_eq("disp_ready", bus.dispatch_ready_o, rdy);
        for (int k = 0; k < DW; k++) begin
            t = m_tail + 4'(k);
            expect_eq("disp_tag", bus.dispatch_tag_o[k*TW +: TW], t);
        end
        if (bus.commit_ready_i)
            for (int i = 0; i < CW; i++)
                if (cv[i]) begin
                    e = q.pop_front();
                    expect_eq("commit_pc", bus.commit_pc_o[i*32 +: 32], e.pc);
                    expect_eq("commit_rd", bus.commit_rd_addr_o[i*5 +: 5], e.rd);
                    expect_eq("commit_result", bus.commit_result_o[i*32 +: 32], m_res[e.tag]);
                    expect_eq("commit_exc", bus.commit_exc_valid_o[i], m_exc[e.tag]);
                    if (m_exc[e.tag])
                        expect_eq("commit_cause", bus.commit_exc_cause_o[i*32 +: 32], m_cause[e.tag]);
                    m_rdy[e.tag] = 1'b0;
                end
        if (bus.flush_i) begin
            model_clear();
        end else begin
            for (int p = NC - 1; p >= 0; p--)
                if (bus.cdb_valid_i[p] && in_rob(bus.cdb_tag_i[p*TW +: TW])) begin
                    t = bus.cdb_tag_i[p*TW +: TW];
                    m_res[t]   = bus.cdb_data_i[p*32 +: 32];
                    m_exc[t]   = bus.cdb_exc_valid_i[p];
                    m_cause[t] = bus.cdb_exc_cause_i[p*32 +: 32];
                    m_rdy[t]   = 1'b1;
                end
            if (bus.mispredict_i) begin
                while (q.size() > 0 && q[$].tag != bus.mispredict_tag_i) begin
                    m_rdy[q[$].tag] = 1'b0;
                    void'(q.pop_back());
                end
                m_tail = bus.mispredict_tag_i + 4'd1;
            end else if (rdy) begin
                for (int k = 0; k < DW; k++) begin
                    if (!bus.dispatch_valid_i[k]) break;
                    e.tag = m_tail;
                    e.pc  = bus.dispatch_pc_i[k*32 +: 32];
                    e.rd  = bus.dispatch_rd_addr_i[k*5 +: 5];
                    q.push_back(e);
                    m_rdy[m_tail] = 1'b0;
                    m_exc[m_tail] = 1'b0;
                    m_tail = m_tail + 4'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.dispatch_valid_i = '0;
        bus.cdb_valid_i      = '0;
        bus.flush_i          = 1'b0;
        bus.mispredict_i     = 1'b0;
    endtask

    task automatic complete_some(input int n, input int exc_pct);
        int p = 0;
        foreach (q[i]) begin
            if (p >= n) break;
            if (!m_rdy[q[i].tag]) begin
                set_cdb(p, q[i].tag, ($urandom_range(0, 99) < exc_pct));
                p++;
            end
        end
    endtask

    task automatic drain();
        bus.commit_ready_i = 1'b1;
        for (int c = 0; c < 64 && q.size() > 0; c++) begin
            complete_some(NC, 0);
            tick();
        end
        expect_eq("drain_count", bus.count_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush_i = 1'b0; bus.mispredict_i = 1'b0; bus.mispredict_tag_i = '0;
        bus.dispatch_valid_i = '0; bus.dispatch_pc_i = '0; bus.dispatch_rd_addr_i = '0;
        bus.cdb_valid_i = '0; bus.cdb_tag_i = '0; bus.cdb_data_i = '0;
        bus.cdb_exc_valid_i = '0; bus.cdb_exc_cause_i = '0; bus.commit_ready_i = 1'b0;
        for (int t = 0; t < N; t++) begin m_res[t] = '0; m_cause[t] = '0; m_exc[t] = 1'b0; end
        model_clear();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_count", bus.count_o, 0);
        expect_eq("rst_ready", bus.dispatch_ready_o, 1);
        expect_eq("rst_cv", bus.commit_valid_o, 0);
        expect_eq("rst_tags", bus.dispatch_tag_o, 8'h10);
        rst_n = 1'b1;

        // Fill to full, then dispatch against a full ROB.
        repeat (8) begin set_disp(2); tick(); end
        expect_eq("full_count", bus.count_o, 16);
        expect_eq("full_ready", bus.dispatch_ready_o, 0);
        set_disp(2); tick();
        expect_eq("full_ignored", bus.count_o, 16);
        drain();

        // Out-of-order completion, head blocks commit; port 0 wins tag clash.
        bus.commit_ready_i = 1'b1;
        set_disp(2); tick(); set_disp(2); tick();
        set_cdb(0, 4'd3, 1'b0); set_cdb(1, 4'd3, 1'b0); tick();
        set_cdb(0, 4'd2, 1'b0); set_cdb(1, 4'd1, 1'b0); tick();
        expect_eq("ooo_blocked", bus.commit_valid_o, 2'b00);
        set_cdb(0, 4'd0, 1'b0); tick();
        expect_eq("ooo_first", bus.commit_valid_o, 2'b11);
        tick();
        expect_eq("ooo_second", bus.commit_valid_o, 2'b11);
        tick();
        expect_eq("ooo_empty", bus.count_o, 0);

        // Exception on the second of four ready entries (tags 4..7).
        bus.commit_ready_i = 1'b0;
        set_disp(2); tick(); set_disp(2); tick();
        set_cdb(0, 4'd4, 1'b0); set_cdb(1, 4'd5, 1'b1); tick();
        set_cdb(0, 4'd6, 1'b0); set_cdb(1, 4'd7, 1'b0); tick();
        bus.commit_ready_i = 1'b1;
        expect_eq("exc_c1", bus.commit_valid_o, 2'b01);
        tick();
        expect_eq("exc_c2", bus.commit_valid_o, 2'b01);
        expect_eq("exc_c2_flag", bus.commit_exc_valid_o[0], 1);
        tick();
        drain();

        // Move head to 14 and dispatch across the wrap.
        repeat (3) begin set_disp(2); tick(); end
        drain();
        bus.commit_ready_i = 1'b0;
        set_disp(2);
        expect_eq("wrap_tags_a", bus.dispatch_tag_o, 8'hFE);
        tick();
        set_disp(2);
        expect_eq("wrap_tags_b", bus.dispatch_tag_o, 8'h10);
        tick();
        drain();

        // Partial flush while two entries retire.
        bus.flush_i = 1'b1; tick();
        bus.commit_ready_i = 1'b0;
        repeat (3) begin set_disp(2); tick(); end
        set_cdb(0, 4'd0, 1'b0); set_cdb(1, 4'd1, 1'b0); tick();
        bus.commit_ready_i = 1'b1;
        bus.mispredict_i = 1'b1; bus.mispredict_tag_i = 4'd2; set_disp(2);
        tick();
        expect_eq("mp_count", bus.count_o, 1);
        expect_eq("mp_tail", bus.dispatch_tag_o[3:0], 3);
        set_cdb(0, 4'd4, 1'b0); tick();
        expect_eq("mp_cdb_ignored", bus.count_o, 1);
        drain();

        // Flush overrides everything in the same cycle.
        set_disp(2); tick();
        complete_some(2, 0); tick();
        bus.flush_i = 1'b1; bus.mispredict_i = 1'b1; bus.mispredict_tag_i = 4'd5;
        set_disp(2); set_cdb(0, 4'd2, 1'b0);
        tick();
        expect_eq("flush_count", bus.count_o, 0);
        expect_eq("flush_cv", bus.commit_valid_o, 0);
        expect_eq("flush_tags", bus.dispatch_tag_o, 8'h10);

        // Random traffic with occasional exceptions.
        for (int c = 0; c < 60; c++) begin
            bus.commit_ready_i = ($urandom_range(0, 3) != 0);
            set_disp($urandom_range(0, 2));
            complete_some($urandom_range(0, 2), 15);
            tick();
        end
        drain();

        // Asynchronous reset mid-operation.
        bus.commit_ready_i = 1'b0;
        set_disp(2); tick(); set_disp(2); tick();
        rst_n = 1'b0;
        #1;
        expect_eq("arst_count", bus.count_o, 0);
        expect_eq("arst_cv", bus.commit_valid_o, 0);
        expect_eq("arst_ready", bus.dispatch_ready_o, 1);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_disp(1); tick();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/superscalar_rob.md
SUPERSCALAR_ROB -- requirements
Module: superscalar_rob

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, result width; PC_WIDTH, default 32, PC width; REG_ADDR_WIDTH, default 5, rd width; ROB_SIZE, default 16, entries (power of 2, >=4); DISPATCH_WIDTH (DW), default 2, dispatch lanes; COMMIT_WIDTH (CW), default 2, commit lanes; NUM_CDB, default 2, result ports; TW = $clog2(ROB_SIZE).
REQ-002 SHALL have ports: clk_i in 1 clock; rst_ni in 1 async active-low reset.
REQ-003 SHALL have ports: flush_i in 1 full flush; mispredict_i in 1 partial flush; mispredict_tag_i in TW, last surviving entry.
REQ-004 SHALL have ports: dispatch_valid_i in DW; dispatch_pc_i in DW*PC_WIDTH; dispatch_rd_addr_i in DW*REG_ADDR_WIDTH; dispatch_ready_o out 1; dispatch_tag_o out DW*TW, tag per lane.
REQ-005 SHALL have ports: cdb_valid_i in NUM_CDB; cdb_tag_i in NUM_CDB*TW; cdb_data_i in NUM_CDB*DATA_WIDTH; cdb_exc_valid_i in NUM_CDB; cdb_exc_cause_i in NUM_CDB*32.
REQ-006 SHALL have ports: commit_valid_o out CW; commit_pc_o, commit_rd_addr_o, commit_result_o, commit_exc_valid_o, commit_exc_cause_o out CW lanes each; commit_ready_i in 1; count_o out TW+1, occupied entries.

Function
REQ-007 Entry SHALL hold: busy, ready, pc, rd_addr, result, exc_valid, exc_cause; head/tail TW bits wrapping modulo ROB_SIZE; count TW+1 bits, 0..ROB_SIZE.
REQ-008 dispatch_ready_o SHALL be 1 iff ROB_SIZE - count >= DW (combinational on registered state).
REQ-009 dispatch_valid_i SHALL be contiguous from lane 0; lane k gets tag tail+k (mod ROB_SIZE), dispatch_tag_o valid every cycle regardless of valid.
REQ-010 When dispatch_ready_o=1, each valid lane SHALL write its entry next cycle with busy=1, ready=0, exc cleared; tail and count advance by the number of valid lanes.
REQ-011 Each cdb port SHALL, when valid and target entry busy=1, write result/exc and set ready=1 next cycle; writes to non-busy entries SHALL be ignored; same tag on two ports: lowest port index wins.
REQ-012 Commit lane i valid iff i < count, entry head+i ready, no entry head+j (j<i) has exc_valid, and (i==0 or entry head+i exc_valid=0); commit_valid_o SHALL be a contiguous prefix.
REQ-013 Commit outputs SHALL be combinational from registered state; when commit_ready_i=1 all valid lanes retire: busy cleared, head and count advance by retired lanes.
REQ-014 Simultaneous dispatch and commit SHALL both occur; count_next = count + dispatched - retired.
REQ-015 mispredict_i SHALL squash all entries younger than mispredict_tag_i (busy cleared), set tail = mispredict_tag_i+1, drop same-cycle dispatch; same-cycle commits still retire.
REQ-016 On mispredict, with age = (mispredict_tag_i - head) mod ROB_SIZE and k retired lanes: count_next = 0 if age < k, else age+1-k.
REQ-017 flush_i SHALL clear head, tail, count and all busy/ready bits next cycle, overriding mispredict, dispatch, commit and cdb writes; priority flush_i > mispredict_i > normal.
REQ-018 Full (count=ROB_SIZE) SHALL commit normally; empty SHALL drive commit_valid_o=0.

Reset
REQ-019 rst_ni low SHALL asynchronously clear head, tail, count, busy and ready; outputs: dispatch_ready_o=1, commit_valid_o=0, count_o=0, dispatch_tag_o lane k=k.
REQ-020 Payload fields need no reset; a reset mid-operation SHALL discard all in-flight entries.

Verification
REQ-021 Reset, dispatch 2/cycle for 8 cycles, ROB_SIZE=16 -> tags 0..15, count_o=16, dispatch_ready_o=0; further dispatch ignored.
REQ-022 Fill 4, cdb completes tags 3,2,1 -> commit_valid_o=00; complete tag 0 -> 11 (tags 0,1), next cycle 11 (tags 2,3), count_o=0.
REQ-023 Entries 0..3 ready, tag 1 exc_valid=1 -> cycle1 lane0 only (tag0), cycle2 lane0 tag1 with exc, lane1=0.
REQ-024 head=14, tail wraps: dispatch 4 -> tags 14,15,0,1; commit in order across wrap.
REQ-025 count=6 at head=0, mispredict_tag_i=2 with 2 retiring -> count_o=1, tail=3; cdb to tag 4 next cycle ignored.
REQ-026 flush_i with simultaneous dispatch, cdb, mispredict -> count_o=0, head=tail=0, commit_valid_o=0.
